inst_decode: RTL and testbench

- Decode stage directly downstream of instruction fetch; owns the architectural fetch PC.
- Drives the fetch request packet `dec2if_o` (pc, pcValid) and consumes the fetch result packet `if2dec_i` (pc, instValid, inst32).
- Decodes RV32I into a registered `dec2ex_o` packet.
- Resolves JAL redirects locally, accepts branch/JALR redirects from execute, and halts fetch on illegal/system instructions.

---
 rtl/inst_decode_pkg.sv | 82 ++++++++
 rtl/rv32i_imm_gen.sv | 20 ++
 rtl/inst_decode.sv | 202 ++++++++++++++++++++
 tb/tb_inst_decode.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_decode_pkg.sv
// Shared types for the RV32I decode stage: interface packets, opcode constants,
// operation classes and the fetch-control FSM states.
package inst_decode_pkg;

  typedef enum logic [3:0] {
    OC_NONE,
    OC_LUI,
    OC_AUIPC,
    OC_JAL,
    OC_JALR,
    OC_BRANCH,
    OC_LOAD,
    OC_STORE,
    OC_OPIMM,
    OC_OP,
    OC_FENCE,
    OC_SYSTEM
  } opClass_e;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } decState_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic [29:0] pc;
    logic        instValid;
    logic [31:0] inst32;
  } if2decPkt;

  typedef struct packed {
    logic [29:0] pc;
    logic        pcValid;
  } dec2ifPkt;

  typedef struct packed {
    logic        redirValid;
    logic [29:0] redirPc;
  } ex2decPkt;

  typedef struct packed {
    logic        valid;
    logic [29:0] pc;
    opClass_e    opClass;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm32;
    logic        illegal;
  } dec2exPkt;

  // Register-register ops: funct7 0 allows every funct3; 0x20 only SUB and SRA.
  function automatic logic opRegLegal(input logic [2:0] f3, input logic [6:0] f7);
    logic ok;
    ok = 1'b0;
    if (f7 == 7'h00) begin
      ok = 1'b1;
    end else if (f7 == 7'h20) begin
      ok = (f3 == 3'b000) || (f3 == 3'b101);
    end
    return ok;
  endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational RV32I immediate extraction: every format is produced in parallel,
// sign-extended to 32 bits, and the decoder picks the one matching the opcode.
module rv32i_imm_gen (
  input  logic [31:0] i_inst32,
  output logic [31:0] o_immI,
  output logic [31:0] o_immS,
  output logic [31:0] o_immB,
  output logic [31:0] o_immU,
  output logic [31:0] o_immJ
);

  assign o_immI = {{20{i_inst32[31]}}, i_inst32[31:20]};
  assign o_immS = {{20{i_inst32[31]}}, i_inst32[31:25], i_inst32[11:7]};
  assign o_immB = {{19{i_inst32[31]}}, i_inst32[31], i_inst32[7],
                   i_inst32[30:25], i_inst32[11:8], 1'b0};
  assign o_immU = {i_inst32[31:12], 12'b0};
  assign o_immJ = {{11{i_inst32[31]}}, i_inst32[31], i_inst32[19:12],
                   i_inst32[20], i_inst32[30:21], 1'b0};

endmodule

// File: rtl/inst_decode.sv
// RV32I decode stage: owns the fetch PC, resolves JAL locally, takes branch/JALR
// redirects from execute and stops fetch on illegal or system instructions.
module inst_decode
  import inst_decode_pkg::*;
#(
  parameter logic [29:0] RESET_PC       = 30'h0000_0000,
  parameter bit          HALT_ON_SYSTEM = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     stall,
  input  if2decPkt if2dec_i,
  output dec2ifPkt dec2if_o,
  input  ex2decPkt ex2dec_i,
  output dec2exPkt dec2ex_o,
  output logic     halted_o
);

  decState_e   r_state;
  logic [29:0] r_pcReg;
  logic        r_pcValid;
  logic        r_halted;
  dec2exPkt    r_dec2ex;

  logic [31:0] w_inst;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_immI, w_immS, w_immB, w_immU, w_immJ;
  opClass_e    w_opClass;
  logic [31:0] w_imm32;
  logic        w_illegal;
  logic        w_isSystem;
  logic        w_accept;
  logic        w_jalTaken;
  logic        w_haltReq;
  logic [29:0] w_jalTarget;
  logic [29:0] w_nextPc;

  assign w_inst   = if2dec_i.inst32;
  assign w_opcode = w_inst[6:0];
  assign w_funct3 = w_inst[14:12];
  assign w_funct7 = w_inst[31:25];

  rv32i_imm_gen u_immGen (
    .i_inst32 (w_inst),
    .o_immI   (w_immI),
    .o_immS   (w_immS),
    .o_immB   (w_immB),
    .o_immU   (w_immU),
    .o_immJ   (w_immJ)
  );

  always_comb begin
    w_opClass  = OC_NONE;
    w_imm32    = '0;
    w_illegal  = 1'b0;
    w_isSystem = 1'b0;
    case (w_opcode)
      OPC_LUI:   begin w_opClass = OC_LUI;   w_imm32 = w_immU; end
      OPC_AUIPC: begin w_opClass = OC_AUIPC; w_imm32 = w_immU; end
      OPC_JAL: begin
        w_opClass = OC_JAL;
        w_imm32   = w_immJ;
        w_illegal = w_immJ[1];
      end
      OPC_JALR: begin
        w_opClass = OC_JALR;
        w_imm32   = w_immI;
        w_illegal = (w_funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        w_opClass = OC_BRANCH;
        w_imm32   = w_immB;
        w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
      end
      OPC_LOAD: begin
        w_opClass = OC_LOAD;
        w_imm32   = w_immI;
        w_illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
      end
      OPC_STORE: begin
        w_opClass = OC_STORE;
        w_imm32   = w_immS;
        w_illegal = (w_funct3 > 3'b010);
      end
      OPC_OPIMM: begin
        w_opClass = OC_OPIMM;
        w_imm32   = w_immI;
        if (w_funct3 == 3'b001) begin
          w_illegal = (w_funct7 != 7'h00);
        end else if (w_funct3 == 3'b101) begin
          w_illegal = (w_funct7 != 7'h00) && (w_funct7 != 7'h20);
        end
      end
      OPC_OP: begin
        w_opClass = OC_OP;
        w_illegal = !opRegLegal(w_funct3, w_funct7);
      end
      OPC_FENCE: begin
        w_opClass = OC_FENCE;
        w_imm32   = w_immI;
        w_illegal = (w_funct3 != 3'b000);
      end
      OPC_SYSTEM: begin
        // With halting disabled ECALL/EBREAK become plain NOPs for execute.
        if ((w_inst == INST_ECALL) || (w_inst == INST_EBREAK)) begin
          w_isSystem = 1'b1;
          if (HALT_ON_SYSTEM) begin
            w_opClass = OC_SYSTEM;
            w_imm32   = w_immI;
          end
        end else begin
          w_illegal = 1'b1;
        end
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_inst[1:0] != 2'b11) begin
      w_opClass = OC_NONE;
      w_illegal = 1'b1;
    end
  end

  assign w_accept    = if2dec_i.instValid && (r_state == ST_RUN) && !ex2dec_i.redirValid;
  assign w_jalTaken  = w_accept && (w_opClass == OC_JAL) && !w_illegal;
  assign w_haltReq   = w_accept && (w_illegal || (w_isSystem && HALT_ON_SYSTEM));
  assign w_jalTarget = if2dec_i.pc + w_immJ[31:2];

  // Redirect and JAL steer the request in the same cycle so no wrong-path fetch is issued.
  always_comb begin
    w_nextPc = r_pcReg;
    if (ex2dec_i.redirValid) begin
      w_nextPc = ex2dec_i.redirPc;
    end else if (w_jalTaken) begin
      w_nextPc = w_jalTarget;
    end
  end

  assign dec2if_o.pc      = w_nextPc;
  assign dec2if_o.pcValid = r_pcValid;
  assign halted_o         = r_halted;
  assign dec2ex_o         = r_dec2ex;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_BOOT;
      r_pcReg   <= RESET_PC;
      r_pcValid <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state   <= ST_RUN;
          r_pcValid <= 1'b1;
        end
        ST_RUN: begin
          if (!stall) begin
            r_pcReg <= w_nextPc + 30'd1;
            if (w_haltReq) begin
              r_state   <= ST_HALT;
              r_pcValid <= 1'b0;
              r_halted  <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          if (!stall && ex2dec_i.redirValid) begin
            r_pcReg   <= ex2dec_i.redirPc;
            r_state   <= ST_RUN;
            r_pcValid <= 1'b1;
            r_halted  <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_BOOT;
          r_pcValid <= 1'b0;
          r_halted  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dec2ex    <= '0;
      r_dec2ex.pc <= '1;
    end else if (!stall) begin
      r_dec2ex.valid    <= w_accept && !w_illegal;
      r_dec2ex.illegal  <= w_accept && w_illegal;
      r_dec2ex.pc       <= if2dec_i.pc;
      r_dec2ex.opClass  <= w_opClass;
      r_dec2ex.funct3   <= w_funct3;
      r_dec2ex.funct7b5 <= w_inst[30];
      r_dec2ex.rd       <= w_inst[11:7];
      r_dec2ex.rs1      <= w_inst[19:15];
      r_dec2ex.rs2      <= w_inst[24:20];
      r_dec2ex.imm32    <= w_imm32;
    end
  end

endmodule

// File: tb/tb_inst_decode.sv
// Directed bench for inst_decode: a small fetch model serves instructions from a
// sparse memory and a queue holds the decode results due on the following edge.
module tb_inst_decode;
  import inst_decode_pkg::*;

  logic     clk;
  logic     rst;
  logic     stall;
  if2decPkt if2dec;
  dec2ifPkt dec2if;
  ex2decPkt ex2dec;
  dec2exPkt dec2ex;
  logic     halted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        full;
    logic        valid;
    logic        illegal;
    logic [29:0] pc;
    opClass_e    oc;
    logic [4:0]  rd;
    logic [31:0] imm;
  } expEntry_t;

  expEntry_t expQ[$];
  logic [31:0] mem [logic [29:0]];

  inst_decode #(
    .RESET_PC       (30'h100),
    .HALT_ON_SYSTEM (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .if2dec_i (if2dec),
    .dec2if_o (dec2if),
    .ex2dec_i (ex2dec),
    .dec2ex_o (dec2ex),
    .halted_o (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memRead(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0000_0013;
  endfunction

  // Fetch answers a request from cycle N at N+1 and freezes with the pipeline.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      if2dec.pc        <= '0;
      if2dec.instValid <= 1'b0;
      if2dec.inst32    <= '0;
    end else if (!stall) begin
      if2dec.pc        <= dec2if.pc;
      if2dec.instValid <= dec2if.pcValid;
      if2dec.inst32    <= memRead(dec2if.pc);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkFetch(input string tag, input logic v, input logic [29:0] pc);
    checkOutput({tag, ".pcValid"}, 32'(dec2if.pcValid), 32'(v));
    if (v) checkOutput({tag, ".pc"}, 32'(dec2if.pc), 32'(pc));
  endtask

  task automatic pushExp(input logic full, input logic v, input logic ill, input logic [29:0] pc,
                         input opClass_e oc, input logic [4:0] rd, input logic [31:0] imm);
    expEntry_t e;
    e.full = full; e.valid = v; e.illegal = ill; e.pc = pc; e.oc = oc; e.rd = rd; e.imm = imm;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic st, input logic rv, input logic [29:0] rp);
    stall             = st;
    ex2dec.redirValid = rv;
    ex2dec.redirPc    = rp;
    #1;
  endtask

  task automatic tick();
    expEntry_t e;
    @(posedge clk);
    #1;
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      checkOutput("dec2ex.valid", 32'(dec2ex.valid), 32'(e.valid));
      checkOutput("dec2ex.illegal", 32'(dec2ex.illegal), 32'(e.illegal));
      checkOutput("dec2ex.pc", 32'(dec2ex.pc), 32'(e.pc));
      if (e.full) begin
        checkOutput("dec2ex.opClass", 32'(dec2ex.opClass), 32'(e.oc));
        checkOutput("dec2ex.rd", 32'(dec2ex.rd), 32'(e.rd));
        checkOutput("dec2ex.imm32", dec2ex.imm32, e.imm);
      end
    end
  endtask

  initial begin
    mem[30'h100] = 32'h0050_0093;  // addi x1,x0,5
    mem[30'h101] = 32'h1234_5137;  // lui  x2,0x12345
    mem[30'h102] = 32'h0020_81B3;  // add  x3,x1,x2
    mem[30'h103] = 32'h0030_A423;  // sw   x3,8(x1)
    mem[30'h104] = 32'h3F00_006F;  // jal  x0,+0x3f0 -> 0x200
    mem[30'h200] = 32'h0100_006F;  // jal  x0,+16    -> 0x204
    mem[30'h201] = 32'hFFFF_FFFF;
    mem[30'h204] = 32'hFFF0_0293;  // addi x5,x0,-1
    mem[30'h205] = 32'hFE20_8CE3;  // beq  x1,x2,-8
    mem[30'h042] = 32'hFFFF_FFFF;
    mem[30'h080] = 32'h0000_0073;  // ecall
    mem[30'h090] = 32'h0060_006F;  // jal  x0,+6 (misaligned)
    mem[30'h000] = 32'h0100_006F;  // jal  x0,+16

    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 30'h0);
    #12;
    checkFetch("reset", 1'b0, 30'h0);
    checkOutput("reset.pcFwd", 32'(dec2if.pc), 32'(30'h100));
    checkOutput("reset.halted", 32'(halted), 32'h0);
    checkOutput("reset.dec2ex.valid", 32'(dec2ex.valid), 32'h0);
    checkOutput("reset.dec2ex.pc", 32'(dec2ex.pc), 32'(30'h3fffffff));

    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkFetch("boot", 1'b0, 30'h0);
    tick();
    checkFetch("run0", 1'b1, 30'h100);
    tick();
    checkFetch("run1", 1'b1, 30'h101);
    pushExp(1, 1, 0, 30'h100, OC_OPIMM, 5'd1, 32'd5);
    tick();
    checkFetch("run2", 1'b1, 30'h102);
    pushExp(1, 1, 0, 30'h101, OC_LUI, 5'd2, 32'h1234_5000);
    tick();
    checkFetch("run3", 1'b1, 30'h103);

    applyStimulus(1'b1, 1'b0, 30'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkFetch("stall", 1'b1, 30'h103);
      checkOutput("stall.dec2ex.pc", 32'(dec2ex.pc), 32'(30'h101));
      checkOutput("stall.dec2ex.imm", dec2ex.imm32, 32'h1234_5000);
    end
    applyStimulus(1'b0, 1'b0, 30'h0);
    pushExp(1, 1, 0, 30'h102, OC_OP, 5'd3, 32'd0);
    tick();
    checkFetch("unstall", 1'b1, 30'h104);
    pushExp(1, 1, 0, 30'h103, OC_STORE, 5'd8, 32'd8);
    tick();
    checkFetch("jal1.redirect", 1'b1, 30'h200);
    pushExp(1, 1, 0, 30'h104, OC_JAL, 5'd0, 32'h3F0);
    tick();
    checkFetch("jal2.redirect", 1'b1, 30'h204);
    pushExp(1, 1, 0, 30'h200, OC_JAL, 5'd0, 32'h10);
    tick();
    checkFetch("jal2.next", 1'b1, 30'h205);
    pushExp(1, 1, 0, 30'h204, OC_OPIMM, 5'd5, 32'hFFFF_FFFF);
    tick();
    pushExp(1, 1, 0, 30'h205, OC_BRANCH, 5'd25, 32'hFFFF_FFF8);
    tick();
    checkOutput("wrongPath.halted", 32'(halted), 32'h0);

    applyStimulus(1'b0, 1'b1, 30'h40);
    checkFetch("redir.same", 1'b1, 30'h40);
    pushExp(0, 0, 0, 30'h206, OC_NONE, 5'd0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 30'h0);
    checkFetch("redir.next", 1'b1, 30'h41);
    pushExp(1, 1, 0, 30'h40, OC_OPIMM, 5'd0, 32'd0);
    tick();
    pushExp(1, 1, 0, 30'h41, OC_OPIMM, 5'd0, 32'd0);
    tick();
    pushExp(0, 0, 1, 30'h42, OC_NONE, 5'd0, 32'd0);
    tick();
    checkOutput("illegal.halted", 32'(halted), 32'h1);
    checkFetch("illegal.stop", 1'b0, 30'h0);
    pushExp(0, 0, 0, 30'h43, OC_NONE, 5'd0, 32'd0);
    tick();
    checkOutput("halt.hold", 32'(halted), 32'h1);

    applyStimulus(1'b0, 1'b1, 30'h80);
    tick();
    applyStimulus(1'b0, 1'b0, 30'h0);
    checkFetch("resume80", 1'b1, 30'h80);
    checkOutput("resume80.halted", 32'(halted), 32'h0);
    tick();
    pushExp(1, 1, 0, 30'h80, OC_SYSTEM, 5'd0, 32'd0);
    tick();
    checkOutput("ecall.halted", 32'(halted), 32'h1);
    checkFetch("ecall.stop", 1'b0, 30'h0);

    applyStimulus(1'b0, 1'b1, 30'h90);
    tick();
    applyStimulus(1'b0, 1'b0, 30'h0);
    checkFetch("resume90", 1'b1, 30'h90);
    tick();
    checkFetch("misJal.noRedirect", 1'b1, 30'h91);
    pushExp(0, 0, 1, 30'h90, OC_NONE, 5'd0, 32'd0);
    tick();
    checkOutput("misJal.halted", 32'(halted), 32'h1);
    checkFetch("misJal.stop", 1'b0, 30'h0);

    applyStimulus(1'b0, 1'b1, 30'h3fffffff);
    tick();
    applyStimulus(1'b0, 1'b0, 30'h0);
    checkFetch("wrap.top", 1'b1, 30'h3fffffff);
    tick();
    checkFetch("wrap.zero", 1'b1, 30'h0);
    tick();
    checkFetch("jal0.redirect", 1'b1, 30'h4);

    rst = 1'b0;
    #1;
    checkFetch("asyncRst", 1'b0, 30'h0);
    checkOutput("asyncRst.pcFwd", 32'(dec2if.pc), 32'(30'h100));
    checkOutput("asyncRst.dec2ex.valid", 32'(dec2ex.valid), 32'h0);
    checkOutput("asyncRst.dec2ex.pc", 32'(dec2ex.pc), 32'(30'h3fffffff));
    checkOutput("asyncRst.halted", 32'(halted), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkFetch("reboot", 1'b0, 30'h0);
    tick();
    checkFetch("reboot.run", 1'b1, 30'h100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
